// File: rtl/auto_nav_scheduler.sv
// Auto-drive sequencer: debounces the obstacle detectors, picks a manoeuvre with a
// right-hand-wall rule, and handshakes trigger pulses with the turning unit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | auto-drive off, all outputs low, turn_count held
// SETTLE   | driving forward after a turn/pass, detectors ignored
// CRUISE   | driving forward along a corridor (V == 011)
// SCAN     | stopped, debouncing the detector vector
// ISSUE    | one-cycle trigger pulse to the turning unit
// WAIT_ACK | waiting for is_turning to rise, bounded by ACK_TIMEOUT
// TURNING  | turning unit busy, waiting for it to finish
// FAULT    | turning unit never acknowledged; only rst or enable=0 exit
module auto_nav_scheduler #(
  parameter int unsigned DEBOUNCE      = 10,
  parameter int unsigned SETTLE_CYCLES = 500,
  parameter int unsigned ACK_TIMEOUT   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       detect_front,
  input  logic       detect_left,
  input  logic       detect_right,
  input  logic       is_turning,
  output logic       trigger_turn_left,
  output logic       trigger_turn_right,
  output logic       trigger_turn_back,
  output logic       move_forward,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] turn_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_CRUISE   = 3'd2,
    S_SCAN     = 3'd3,
    S_ISSUE    = 3'd4,
    S_WAIT_ACK = 3'd5,
    S_TURNING  = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'd0,
    TURN_LEFT  = 2'd1,
    TURN_RIGHT = 2'd2,
    TURN_BACK  = 2'd3
  } turn_t;

  localparam logic [15:0] DEBOUNCE_C = 16'(DEBOUNCE);
  localparam logic [15:0] SETTLE_C   = 16'(SETTLE_CYCLES);
  localparam logic [15:0] ACK_C      = 16'(ACK_TIMEOUT);
  localparam logic [2:0]  CORRIDOR   = 3'b011;

  state_t      state_q, state_d;
  turn_t       code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [15:0] scan_cnt;
  logic [2:0]  v, v_prev;
  logic [7:0]  turn_count_d;

  assign v       = {detect_front, detect_left, detect_right};
  assign cnt_inc = cnt_q + 16'd1;

  // Debounce count this cycle would reach; saturates so a held is_turning cannot wrap it.
  always_comb begin
    if ((cnt_q == 16'd0) || (v != v_prev))
      scan_cnt = 16'd1;
    else if (cnt_q >= DEBOUNCE_C)
      scan_cnt = DEBOUNCE_C;
    else
      scan_cnt = cnt_inc;
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    turn_count_d = turn_count;

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (enable)
          state_d = S_SCAN;
      end

      S_SCAN: begin
        if (scan_cnt >= DEBOUNCE_C) begin
          cnt_d = DEBOUNCE_C;
          if (!is_turning) begin
            if (v == CORRIDOR) begin
              state_d = S_CRUISE;
            end else if (!v[0]) begin
              code_d  = TURN_RIGHT;
              state_d = S_ISSUE;
            end else if (!v[2]) begin
              state_d = S_SETTLE;
            end else if (!v[1]) begin
              code_d  = TURN_LEFT;
              state_d = S_ISSUE;
            end else begin
              code_d  = TURN_BACK;
              state_d = S_ISSUE;
            end
          end
        end else begin
          cnt_d = scan_cnt;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        // An acknowledge on the timeout cycle still wins over the fault.
        if (is_turning) begin
          state_d      = S_TURNING;
          turn_count_d = turn_count + 8'd1;
        end else if (cnt_inc >= ACK_C) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_TURNING: begin
        if (!is_turning)
          state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt_inc >= SETTLE_C)
          state_d = S_CRUISE;
        else
          cnt_d = cnt_inc;
      end

      S_CRUISE: begin
        if (v != CORRIDOR)
          state_d = S_SCAN;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable) begin
      state_d      = S_IDLE;
      turn_count_d = turn_count;
    end

    // Every state entry starts its timer from zero.
    if (state_d != state_q)
      cnt_d = 16'd0;
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      code_q             <= TURN_NONE;
      cnt_q              <= 16'd0;
      v_prev             <= 3'b000;
      turn_count         <= 8'd0;
      trigger_turn_left  <= 1'b0;
      trigger_turn_right <= 1'b0;
      trigger_turn_back  <= 1'b0;
      move_forward       <= 1'b0;
      fault              <= 1'b0;
    end else begin
      state_q            <= state_d;
      code_q             <= code_d;
      cnt_q              <= cnt_d;
      v_prev             <= v;
      turn_count         <= turn_count_d;
      trigger_turn_left  <= (state_d == S_ISSUE) && (code_d == TURN_LEFT);
      trigger_turn_right <= (state_d == S_ISSUE) && (code_d == TURN_RIGHT);
      trigger_turn_back  <= (state_d == S_ISSUE) && (code_d == TURN_BACK);
      move_forward       <= (state_d == S_SETTLE) || (state_d == S_CRUISE);
      fault              <= (state_d == S_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_auto_nav_scheduler.sv
// Directed bench for auto_nav_scheduler with DEBOUNCE=4, SETTLE_CYCLES=8, ACK_TIMEOUT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_auto_nav_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       detect_front;
  logic       detect_left;
  logic       detect_right;
  logic       is_turning;
  logic       trigger_turn_left;
  logic       trigger_turn_right;
  logic       trigger_turn_back;
  logic       move_forward;
  logic       fault;
  logic [2:0] state;
  logic [7:0] turn_count;

  int checks = 0;
  int errors = 0;

  auto_nav_scheduler #(
    .DEBOUNCE     (4),
    .SETTLE_CYCLES(8),
    .ACK_TIMEOUT  (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .detect_front      (detect_front),
    .detect_left       (detect_left),
    .detect_right      (detect_right),
    .is_turning        (is_turning),
    .trigger_turn_left (trigger_turn_left),
    .trigger_turn_right(trigger_turn_right),
    .trigger_turn_back (trigger_turn_back),
    .move_forward      (move_forward),
    .fault             (fault),
    .state             (state),
    .turn_count        (turn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_v(input logic [2:0] vec);
    {detect_front, detect_left, detect_right} = vec;
  endtask

  function automatic logic [7:0] trig();
    return {5'b0, trigger_turn_left, trigger_turn_right, trigger_turn_back};
  endfunction

  // Four debounce cycles in SCAN, then the decided state on the fifth.
  task automatic scan_to(input string tag, input logic [2:0] exp_state, input logic [2:0] exp_trig);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_scan_state"}, 8'(state), 8'd3);
      chk({tag, "_scan_trig"}, trig(), 8'd0);
    end
    tick();
    chk({tag, "_decided_state"}, 8'(state), 8'(exp_state));
    chk({tag, "_decided_trig"}, trig(), 8'(exp_trig));
  endtask

  // From ISSUE: one WAIT_ACK cycle, a one-cycle busy pulse, then SETTLE.
  task automatic turn_ack(input string tag, input logic [7:0] exp_count);
    tick();
    chk({tag, "_wait_state"}, 8'(state), 8'd5);
    chk({tag, "_wait_trig"}, trig(), 8'd0);
    is_turning = 1'b1;
    tick();
    chk({tag, "_turning_state"}, 8'(state), 8'd6);
    chk({tag, "_turn_count"}, turn_count, exp_count);
    is_turning = 1'b0;
    tick();
    chk({tag, "_settle_state"}, 8'(state), 8'd1);
  endtask

  // Observed in SETTLE cycle 1: seven more SETTLE cycles, then CRUISE.
  task automatic settle_to_cruise(input string tag);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk({tag, "_settle_state"}, 8'(state), 8'd1);
      chk({tag, "_settle_mf"}, 8'(move_forward), 8'd1);
    end
    tick();
    chk({tag, "_cruise_state"}, 8'(state), 8'd2);
    chk({tag, "_cruise_mf"}, 8'(move_forward), 8'd1);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    is_turning = 1'b0;
    set_v(3'b011);
    tick();
    tick();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_count", turn_count, 8'd0);
    chk("rst_trig", trig(), 8'd0);
    chk("rst_mf", 8'(move_forward), 8'd0);
    chk("rst_fault", 8'(fault), 8'd0);

    // 1: corridor from enable
    rst    = 1'b0;
    enable = 1'b1;
    scan_to("t1", 3'd2, 3'b000);
    chk("t1_mf", 8'(move_forward), 8'd1);

    // 2: right turn, busy for 6 sampled cycles starting the cycle after the trigger
    set_v(3'b110);
    scan_to("t2", 3'd4, 3'b010);
    chk("t2_count_before", turn_count, 8'd0);
    tick();
    chk("t2_wait_state", 8'(state), 8'd5);
    chk("t2_pulse_width", trig(), 8'd0);
    is_turning = 1'b1;
    tick();
    chk("t2_turning_state", 8'(state), 8'd6);
    chk("t2_count", turn_count, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_turning_hold", 8'(state), 8'd6);
      chk("t2_turning_mf", 8'(move_forward), 8'd0);
    end
    is_turning = 1'b0;
    set_v(3'b011);
    tick();
    chk("t2_settle_entry", 8'(state), 8'd1);
    chk("t2_settle_mf", 8'(move_forward), 8'd1);
    settle_to_cruise("t2");

    // 3: dead end then left opening
    set_v(3'b111);
    scan_to("t3b", 3'd4, 3'b001);
    turn_ack("t3b", 8'd2);
    set_v(3'b101);
    settle_to_cruise("t3b");
    scan_to("t3l", 3'd4, 3'b100);
    turn_ack("t3l", 8'd3);
    set_v(3'b011);
    settle_to_cruise("t3l");

    // 4: chattering detectors never settle long enough to decide
    for (int i = 0; i < 10; i++) begin
      set_v(((i / 2) % 2 == 0) ? 3'b110 : 3'b011);
      tick();
      chk("t4_chatter_state", 8'(state), 8'd3);
      chk("t4_chatter_trig", trig(), 8'd0);
    end
    set_v(3'b011);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stable_state", 8'(state), 8'd3);
    end
    tick();
    chk("t4_cruise_state", 8'(state), 8'd2);
    chk("t4_trig", trig(), 8'd0);

    // 5: acknowledge never arrives
    set_v(3'b111);
    scan_to("t5", 3'd4, 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_wait_state", 8'(state), 8'd5);
      chk("t5_wait_fault", 8'(fault), 8'd0);
    end
    tick();
    chk("t5_fault_state", 8'(state), 8'd7);
    chk("t5_fault", 8'(fault), 8'd1);
    chk("t5_fault_trig", trig(), 8'd0);
    chk("t5_fault_mf", 8'(move_forward), 8'd0);
    is_turning = 1'b1;
    tick();
    chk("t5_fault_sticky", 8'(state), 8'd7);
    chk("t5_count_held", turn_count, 8'd3);
    is_turning = 1'b0;
    enable     = 1'b0;
    tick();
    chk("t5_idle_state", 8'(state), 8'd0);
    chk("t5_idle_fault", 8'(fault), 8'd0);

    // 6: disable mid-turn, then restart
    enable = 1'b1;
    set_v(3'b110);
    scan_to("t6", 3'd4, 3'b010);
    tick();
    chk("t6_wait_state", 8'(state), 8'd5);
    is_turning = 1'b1;
    tick();
    chk("t6_turning_state", 8'(state), 8'd6);
    chk("t6_count", turn_count, 8'd4);
    enable = 1'b0;
    tick();
    chk("t6_idle_state", 8'(state), 8'd0);
    chk("t6_idle_mf", 8'(move_forward), 8'd0);
    chk("t6_count_kept", turn_count, 8'd4);
    is_turning = 1'b0;
    enable     = 1'b1;
    set_v(3'b011);
    scan_to("t6r", 3'd2, 3'b000);

    // Reset wins over enable
    rst = 1'b1;
    tick();
    chk("rst2_state", 8'(state), 8'd0);
    chk("rst2_count", turn_count, 8'd0);
    chk("rst2_mf", 8'(move_forward), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
